// File: rtl/sha256_pkg.sv
// SHA-256 shared constants, schedule-stream FSM encoding and small-sigma helpers.
// Pure declarations: no latency, no flow control.
package sha256_pkg;

   localparam int WORD_WIDTH   = 32;
   localparam int BLOCK_WIDTH  = 16 * WORD_WIDTH;
   localparam int NUMBER_OF_Ks = 64;
   localparam int WIN_DEPTH    = 16;
   localparam int IDX_WIDTH    = $clog2(NUMBER_OF_Ks);
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUMBER_OF_Ks - 1);

   typedef enum logic [1:0] {
      W_IDLE   = 2'd0,
      W_STREAM = 2'd1,
      W_DONE   = 2'd2
   } w_state_e;

   // Rotations are spelled as concatenations because the word width is fixed at 32.
   function automatic logic [WORD_WIDTH-1:0] sha_sigma0_small(input logic [WORD_WIDTH-1:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [WORD_WIDTH-1:0] sha_sigma1_small(input logic [WORD_WIDTH-1:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

endpackage

// File: rtl/gen_w_sched_calc.sv
// Next schedule word from the sliding window: s1(w14) + w9 + s0(w1) + w0 mod 2^32.
// Combinational, no flow control.
module gen_w_sched_calc
   import sha256_pkg::*;
(
   input  logic [WORD_WIDTH-1:0] i_win_0,
   input  logic [WORD_WIDTH-1:0] i_win_1,
   input  logic [WORD_WIDTH-1:0] i_win_9,
   input  logic [WORD_WIDTH-1:0] i_win_14,
   output logic [WORD_WIDTH-1:0] o_w_next
);

   logic [WORD_WIDTH-1:0] w_s0;
   logic [WORD_WIDTH-1:0] w_s1;

   assign w_s0     = sha_sigma0_small(i_win_1);
   assign w_s1     = sha_sigma1_small(i_win_14);
   assign o_w_next = w_s1 + i_win_9 + w_s0 + i_win_0;

endmodule

// File: rtl/gen_w_stream.sv
// Streams W[0..63] from a padded block via a 16-word window; first word 1 cycle after go, one word/cycle.
// Holds everything while w_ready is low; optional stall counter under GEN_W_STREAM_STALL_CNT_EN.
module gen_w_stream
   import sha256_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   local_go_sig,
   input  logic [BLOCK_WIDTH-1:0] pad_reg,
   input  logic                   w_ready,
   output logic                   regop_w_valid,
   output logic [WORD_WIDTH-1:0]  regop_w_data,
   output logic [IDX_WIDTH-1:0]   regop_w_idx,
   output logic                   regop_w_done
`ifdef GEN_W_STREAM_STALL_CNT_EN
  ,output logic [15:0]            regop_stall_cnt
`endif
);

   w_state_e              r_state;
   logic [WORD_WIDTH-1:0] r_win [WIN_DEPTH];
   logic [IDX_WIDTH-1:0]  r_idx;
   logic [WORD_WIDTH-1:0] w_next;
   logic                  w_go;
   logic                  w_xfer;

   // Go is honoured only in IDLE, so a pulse during DONE is dropped.
   assign w_go   = (r_state == W_IDLE) && local_go_sig;
   assign w_xfer = (r_state == W_STREAM) && w_ready;

   gen_w_sched_calc u_calc (
      .i_win_0  (r_win[0]),
      .i_win_1  (r_win[1]),
      .i_win_9  (r_win[9]),
      .i_win_14 (r_win[14]),
      .o_w_next (w_next)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= W_IDLE;
         r_idx   <= '0;
         for (int i = 0; i < WIN_DEPTH; i++) r_win[i] <= '0;
      end else begin
         case (r_state)
            W_IDLE: begin
               if (w_go) begin
                  for (int i = 0; i < WIN_DEPTH; i++)
                     r_win[i] <= pad_reg[BLOCK_WIDTH-1-WORD_WIDTH*i -: WORD_WIDTH];
                  r_idx   <= '0;
                  r_state <= W_STREAM;
               end
            end
            W_STREAM: begin
               if (w_xfer) begin
                  // The final word stays in r_win[0] so data holds through DONE.
                  if (r_idx == LAST_IDX) begin
                     r_state <= W_DONE;
                  end else begin
                     for (int i = 0; i < WIN_DEPTH-1; i++) r_win[i] <= r_win[i+1];
                     r_win[WIN_DEPTH-1] <= w_next;
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            W_DONE: begin
               r_idx   <= '0;
               r_state <= W_IDLE;
            end
            default: r_state <= W_IDLE;
         endcase
      end
   end

   assign regop_w_valid = (r_state == W_STREAM);
   assign regop_w_done  = (r_state == W_DONE);
   assign regop_w_data  = r_win[0];
   assign regop_w_idx   = r_idx;

`ifdef GEN_W_STREAM_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clock) begin
      if (reset || w_go) begin
         r_stall_cnt <= '0;
      end else if ((r_state == W_STREAM) && !w_ready && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign regop_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_gen_w_stream.sv
// Directed bench for gen_w_stream against a full-array software schedule model.
module tb_gen_w_stream;

   logic         clock = 1'b0;
   logic         reset;
   logic         local_go_sig;
   logic [511:0] pad_reg;
   logic         w_ready;
   logic         regop_w_valid;
   logic [31:0]  regop_w_data;
   logic [5:0]   regop_w_idx;
   logic         regop_w_done;
`ifdef GEN_W_STREAM_STALL_CNT_EN
   logic [15:0]  regop_stall_cnt;
`endif

   int           n_cmp  = 0;
   int           n_fail = 0;
   int           stalls;
   int           cycles;
   logic [31:0]  exp_w [64];
   logic [31:0]  got_w [64];
   logic [511:0] blk_abc;
   logic [511:0] blk_ones;
   logic [511:0] blk_alt;

   always #5 clock = ~clock;

   gen_w_stream dut (
      .clock         (clock),
      .reset         (reset),
      .local_go_sig  (local_go_sig),
      .pad_reg       (pad_reg),
      .w_ready       (w_ready),
      .regop_w_valid (regop_w_valid),
      .regop_w_data  (regop_w_data),
      .regop_w_idx   (regop_w_idx),
      .regop_w_done  (regop_w_done)
`ifdef GEN_W_STREAM_STALL_CNT_EN
     ,.regop_stall_cnt (regop_stall_cnt)
`endif
   );

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x};
      return d[n +: 32];
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   task automatic build_model(input logic [511:0] blk);
      for (int t = 0; t < 16; t++) exp_w[t] = blk[511-32*t -: 32];
      for (int t = 16; t < 64; t++)
         exp_w[t] = ssig1(exp_w[t-2]) + exp_w[t-7] + ssig0(exp_w[t-15]) + exp_w[t-16];
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic start(input logic [511:0] blk);
      pad_reg      = blk;
      local_go_sig = 1'b1;
      tick();
      local_go_sig = 1'b0;
      pad_reg      = blk_alt;
   endtask

   // Consumes one block; flags select ready toggling, a go re-pulse at idx 30,
   // a reset at idx 40, and a go pulse during the done cycle.
   task automatic stream(input string tag, input bit toggle, input bit repulse,
                         input bit abort, input bit go_in_done);
      int got;
      int st16;
      bit rdy;
      got = 0; st16 = 0; stalls = 0; cycles = 0;
      while (got < 64 && cycles < 400) begin
         if (abort && got == 40) begin
            reset   = 1'b1;
            w_ready = 1'b1;
            tick();
            reset = 1'b0;
            chk({tag, "/abort_valid"}, 32'(regop_w_valid), 32'd0);
            chk({tag, "/abort_idx"},   32'(regop_w_idx),   32'd0);
            chk({tag, "/abort_done"},  32'(regop_w_done),  32'd0);
            return;
         end
         if (toggle && got == 16 && st16 < 8) begin
            rdy = 1'b0;
            st16++;
         end else begin
            rdy = toggle ? (cycles % 2 == 0) : 1'b1;
         end
         if (repulse && got == 30) begin
            local_go_sig = 1'b1;
            pad_reg      = blk_ones;
         end
         w_ready = rdy;
         chk({tag, "/valid"}, 32'(regop_w_valid), 32'd1);
         chk({tag, "/idx"},   32'(regop_w_idx),   32'(got));
         chk({tag, "/data"},  regop_w_data,       exp_w[got]);
         got_w[got] = regop_w_data;
         if (rdy) got++;
         else stalls++;
         tick();
         cycles++;
         local_go_sig = 1'b0;
      end
      chk({tag, "/words"}, 32'(got), 32'd64);
      if (!toggle) chk({tag, "/last_xfer_cycle"}, 32'(cycles), 32'd64);
      chk({tag, "/done"},       32'(regop_w_done),  32'd1);
      chk({tag, "/done_valid"}, 32'(regop_w_valid), 32'd0);
      chk({tag, "/done_data"},  regop_w_data,       exp_w[63]);
`ifdef GEN_W_STREAM_STALL_CNT_EN
      chk({tag, "/stall_cnt"}, 32'(regop_stall_cnt), 32'(stalls));
`endif
      if (go_in_done) begin
         local_go_sig = 1'b1;
         pad_reg      = blk_ones;
      end
      tick();
      local_go_sig = 1'b0;
      chk({tag, "/post_done"},  32'(regop_w_done),  32'd0);
      chk({tag, "/post_valid"}, 32'(regop_w_valid), 32'd0);
      chk({tag, "/post_idx"},   32'(regop_w_idx),   32'd0);
`ifdef GEN_W_STREAM_STALL_CNT_EN
      chk({tag, "/stall_hold"}, 32'(regop_stall_cnt), 32'(stalls));
`endif
   endtask

   initial begin
      reset        = 1'b1;
      local_go_sig = 1'b0;
      w_ready      = 1'b0;
      pad_reg      = '0;
      blk_abc      = {32'h61626380, 448'b0, 32'h00000018};
      blk_ones     = '1;
      for (int i = 0; i < 16; i++) blk_alt[32*i +: 32] = $urandom;

      tick();
      tick();
      reset = 1'b0;
      chk("reset/valid", 32'(regop_w_valid), 32'd0);
      chk("reset/idx",   32'(regop_w_idx),   32'd0);
      chk("reset/done",  32'(regop_w_done),  32'd0);
      chk("reset/data",  regop_w_data,       32'd0);
      tick();
      chk("idle/valid", 32'(regop_w_valid), 32'd0);

      // "abc" block at full rate, with hand-computed anchor words.
      build_model(blk_abc);
      start(blk_abc);
      stream("abc", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("abc/W0",  got_w[0],  32'h61626380);
      chk("abc/W15", got_w[15], 32'h00000018);
      chk("abc/W16", got_w[16], 32'h61626380);
      chk("abc/W17", got_w[17], 32'h000F0000);
      chk("abc/W18", got_w[18], 32'h7DA86405);
      chk("abc/W63", got_w[63], 32'h12B1EDEB);

      start(blk_abc);
      stream("abc_stall", 1'b1, 1'b0, 1'b0, 1'b0);

      start(blk_abc);
      stream("rego", 1'b0, 1'b1, 1'b0, 1'b0);

      start(blk_abc);
      stream("abort", 1'b0, 1'b0, 1'b1, 1'b0);
      start(blk_abc);
      stream("restart", 1'b0, 1'b0, 1'b0, 1'b1);

      // Go in the first IDLE cycle after done.
      build_model(blk_alt);
      start(blk_alt);
      stream("b2b", 1'b0, 1'b0, 1'b0, 1'b0);

      build_model(blk_ones);
      start(blk_ones);
      stream("ones", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ones/W16", got_w[16], 32'h203FFFFC);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
